// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-side bus grouping redirect, instruction memory and decode handshake signals
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 7,
  parameter int INSTR_WIDTH = 32
);
  logic                   Enable;
  logic                   Redirect;
  logic [PC_WIDTH-1:0]    RedirectPC;
  logic [PC_WIDTH-1:0]    MemAddr;
  logic                   MemRead;
  logic [INSTR_WIDTH-1:0] MemData;
  logic                   InstValid;
  logic                   InstReady;
  logic [INSTR_WIDTH-1:0] Instruction;
  logic [PC_WIDTH-1:0]    InstPC;
  modport master (
    input  Enable, Redirect, RedirectPC, MemData, InstReady,
    output MemAddr, MemRead, InstValid, Instruction, InstPC
  );
  modport slave (
    output Enable, Redirect, RedirectPC, MemData, InstReady,
    input  MemAddr, MemRead, InstValid, Instruction, InstPC
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: credit-limited instruction fetch with a 2-entry {instruction, PC} queue and branch redirect
module fetch_stage #(
  parameter int                  PC_WIDTH    = 7,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input logic           SysCLK,
  input logic           SysRST,
  fetch_stage_if.master bus
);
  localparam int EW = INSTR_WIDTH + PC_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, REDIR} state_t;
  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [1:0]          count_q, count_d;
  logic                inflight_q, inflight_d, kill_q, kill_d;
  logic [EW-1:0]       e0_q, e0_d, e1_q, e1_d, new_e;
  logic                pop, push, issue, slot1;
  // A read issued in the redirect cycle is still in flight afterwards, so it is marked killed.
  always_comb begin
    pop        = count_q != 2'd0 && bus.InstReady;
    push       = inflight_q && !kill_q && !bus.Redirect;
    issue      = state_q == RUN && bus.Enable && !SysRST &&
                 ({1'b0, count_q} + {2'b0, inflight_q} <= 3'd1 + {2'b0, pop});
    state_d    = bus.Redirect ? REDIR : RUN;
    pc_d       = bus.Redirect ? bus.RedirectPC : issue ? pc_q + 1'b1 : pc_q;
    addr_d     = issue ? pc_q : addr_q;
    inflight_d = issue;
    kill_d     = issue && bus.Redirect;
    new_e      = {bus.MemData, addr_q};
    slot1      = push && (count_q - {1'b0, pop}) != 2'd0;
    e0_d       = push && !slot1 ? new_e : pop ? e1_q : e0_q;
    e1_d       = slot1 ? new_e : e1_q;
    count_d    = bus.Redirect ? 2'd0 : count_q - {1'b0, pop} + {1'b0, push};
  end
  always_ff @(posedge SysCLK) begin
    if (SysRST) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      e0_q       <= '0;
      e1_q       <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
    end
  end
  assign bus.MemRead     = issue;
  assign bus.MemAddr     = issue ? pc_q : addr_q;
  assign bus.InstValid   = count_q != 2'd0;
  assign bus.Instruction = e0_q[EW-1:PC_WIDTH];
  assign bus.InstPC      = e0_q[PC_WIDTH-1:0];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, wrap and random-redirect scoreboard checks for fetch_stage
module tb_fetch_stage;
  logic SysCLK, SysRST;
  int checks = 0;
  int errors = 0;
  fetch_stage_if #(.PC_WIDTH(7), .INSTR_WIDTH(32)) bus ();
  fetch_stage_if #(.PC_WIDTH(7), .INSTR_WIDTH(32)) bw ();
  fetch_stage #(.PC_WIDTH(7), .INSTR_WIDTH(32), .RESET_PC(7'h00)) dut (
    .SysCLK(SysCLK), .SysRST(SysRST), .bus(bus)
  );
  fetch_stage #(.PC_WIDTH(7), .INSTR_WIDTH(32), .RESET_PC(7'h7E)) dut_w (
    .SysCLK(SysCLK), .SysRST(SysRST), .bus(bw)
  );
  function automatic logic [31:0] data_of(input logic [6:0] a);
    return {25'd0, a} * 32'd3;
  endfunction
  always @(posedge SysCLK) begin
    if (bus.MemRead) bus.MemData <= data_of(bus.MemAddr);
    if (bw.MemRead) bw.MemData <= data_of(bw.MemAddr);
  end
  initial begin
    SysCLK = 1'b0;
    forever #5 SysCLK = ~SysCLK;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct packed {
    logic       rst, en, rdy, rd;
    logic [6:0] rpc;
    logic       v, mr;
    logic [6:0] ma, ipc;
  } vec_t;
  function automatic vec_t mk(input logic rst, en, rdy, rd, input logic [6:0] rpc,
                              input logic v, mr, input logic [6:0] ma, ipc);
    return '{rst, en, rdy, rd, rpc, v, mr, ma, ipc};
  endfunction
  localparam int NV = 30;
  vec_t tbl [NV];
  logic [6:0] exp_pc, prev_ma, got [$];
  int stall;
  initial begin
    tbl[0]  = mk(1, 1, 1, 0, 7'h00, 0, 0, 7'h00, 7'h00);
    tbl[1]  = mk(0, 1, 1, 0, 7'h00, 0, 0, 7'h00, 7'h00);
    tbl[2]  = mk(0, 1, 1, 0, 7'h00, 0, 1, 7'h00, 7'h00);
    tbl[3]  = mk(0, 1, 1, 0, 7'h00, 0, 1, 7'h01, 7'h00);
    tbl[4]  = mk(0, 1, 1, 0, 7'h00, 1, 1, 7'h02, 7'h00);
    tbl[5]  = mk(0, 1, 1, 0, 7'h00, 1, 1, 7'h03, 7'h01);
    for (int i = 6; i <= 10; i++) tbl[i] = mk(0, 1, 0, 0, 7'h00, 1, 0, 7'h03, 7'h02);
    tbl[11] = mk(0, 1, 1, 0, 7'h00, 1, 1, 7'h04, 7'h02);
    tbl[12] = mk(0, 1, 1, 1, 7'h40, 1, 1, 7'h05, 7'h03);
    tbl[13] = mk(0, 1, 1, 0, 7'h00, 0, 0, 7'h05, 7'h00);
    tbl[14] = mk(0, 1, 1, 0, 7'h00, 0, 1, 7'h40, 7'h00);
    tbl[15] = mk(0, 1, 1, 0, 7'h00, 0, 1, 7'h41, 7'h00);
    tbl[16] = mk(0, 0, 1, 0, 7'h00, 1, 0, 7'h41, 7'h40);
    tbl[17] = mk(0, 0, 1, 0, 7'h00, 1, 0, 7'h41, 7'h41);
    tbl[18] = mk(0, 0, 1, 0, 7'h00, 0, 0, 7'h41, 7'h00);
    tbl[19] = mk(0, 1, 1, 0, 7'h00, 0, 1, 7'h42, 7'h00);
    tbl[20] = mk(0, 1, 1, 0, 7'h00, 0, 1, 7'h43, 7'h00);
    tbl[21] = mk(0, 1, 1, 1, 7'h10, 1, 1, 7'h44, 7'h42);
    tbl[22] = mk(0, 1, 1, 0, 7'h00, 0, 0, 7'h44, 7'h00);
    tbl[23] = mk(0, 1, 1, 0, 7'h00, 0, 1, 7'h10, 7'h00);
    tbl[24] = mk(0, 1, 1, 0, 7'h00, 0, 1, 7'h11, 7'h00);
    tbl[25] = mk(1, 1, 1, 0, 7'h00, 1, 0, 7'h11, 7'h10);
    tbl[26] = mk(0, 1, 1, 0, 7'h00, 0, 0, 7'h00, 7'h00);
    tbl[27] = mk(0, 1, 1, 0, 7'h00, 0, 1, 7'h00, 7'h00);
    tbl[28] = mk(0, 1, 1, 0, 7'h00, 0, 1, 7'h01, 7'h00);
    tbl[29] = mk(0, 1, 1, 0, 7'h00, 1, 1, 7'h02, 7'h00);
    SysRST = 1'b1;
    bus.Enable = 1'b0; bus.InstReady = 1'b0; bus.Redirect = 1'b0; bus.RedirectPC = '0;
    bw.Enable = 1'b1; bw.InstReady = 1'b1; bw.Redirect = 1'b0; bw.RedirectPC = '0;
    repeat (2) @(posedge SysCLK);
    for (int i = 0; i < NV; i++) begin
      @(negedge SysCLK);
      SysRST = tbl[i].rst; bus.Enable = tbl[i].en; bus.InstReady = tbl[i].rdy;
      bus.Redirect = tbl[i].rd; bus.RedirectPC = tbl[i].rpc;
      #1;
      chk($sformatf("row%0d InstValid", i), {31'd0, bus.InstValid}, {31'd0, tbl[i].v});
      chk($sformatf("row%0d MemRead", i), {31'd0, bus.MemRead}, {31'd0, tbl[i].mr});
      chk($sformatf("row%0d MemAddr", i), {25'd0, bus.MemAddr}, {25'd0, tbl[i].ma});
      if (tbl[i].v) begin
        chk($sformatf("row%0d InstPC", i), {25'd0, bus.InstPC}, {25'd0, tbl[i].ipc});
        chk($sformatf("row%0d Instruction", i), bus.Instruction, data_of(tbl[i].ipc));
      end
    end
    // wrap: RESET_PC=0x7E instance must stream 7E,7F,00,01
    @(negedge SysCLK); SysRST = 1'b1;
    @(negedge SysCLK); SysRST = 1'b0;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      @(negedge SysCLK); #1;
      if (bw.InstValid) begin
        chk("wrap Instruction", bw.Instruction, data_of(bw.InstPC));
        got.push_back(bw.InstPC);
      end
    end
    if (got.size() < 4) begin
      checks++; errors++;
      $display("FAIL wrap timeout: got %0d instructions, required 4", got.size());
    end else begin
      chk("wrap pc0", {25'd0, got[0]}, 32'h7E);
      chk("wrap pc1", {25'd0, got[1]}, 32'h7F);
      chk("wrap pc2", {25'd0, got[2]}, 32'h00);
      chk("wrap pc3", {25'd0, got[3]}, 32'h01);
    end
    // random: output must follow program order, restarting at each redirect target
    @(negedge SysCLK); SysRST = 1'b1; bus.Redirect = 1'b0; bus.Enable = 1'b0;
    exp_pc = 7'h00; prev_ma = 7'h00; stall = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge SysCLK);
      SysRST = 1'b0;
      bus.Enable = $urandom_range(0, 9) < 8;
      bus.InstReady = $urandom_range(0, 9) < 7;
      bus.Redirect = i > 3 && $urandom_range(0, 19) == 0;
      bus.RedirectPC = 7'($urandom);
      #1;
      if (bus.InstValid && bus.InstReady) begin
        chk("rand InstPC", {25'd0, bus.InstPC}, {25'd0, exp_pc});
        chk("rand Instruction", bus.Instruction, data_of(exp_pc));
        exp_pc = exp_pc + 7'd1;
      end
      if (!bus.MemRead) chk("rand MemAddr hold", {25'd0, bus.MemAddr}, {25'd0, prev_ma});
      prev_ma = bus.MemAddr;
      if (bus.Redirect) exp_pc = bus.RedirectPC;
      stall = (bus.Enable && bus.InstReady && !bus.Redirect && !bus.InstValid) ? stall + 1 : 0;
      if (stall > 3) begin
        checks++; errors++;
        $display("FAIL rand starvation: InstValid low %0d cycles, allowed 3", stall);
        stall = 0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
